data_mem_responder: RTL and testbench
=====================================

# data_mem_responder

Word-organised data memory that serves requests from the load/store unit. It sits on the memory side of the load/store interface: active-low chip select, active-low write, 4-bit byte-lane mask, byte address and lane-aligned write data. Every request is latched, held for a programmable number of wait states, committed or read, then acknowledged with a one-cycle `ready`. Out-of-range accesses are flagged with `err`.

## Interface
Parameters:
- `DEPTH_WORDS`, 1024: number of 32-bit words; power of two, 16..65536.
- `WAIT_STATES`, 1: extra cycles between request accept and response; 0..15.
- `BASE_ADDR`, 32'h0000_0000: byte address of word 0; 4-byte aligned.

Ports (one clock; reset is asynchronous and active-low):
- `clk` in 1: clock; all state changes on the rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `cs` in 1: chip select, active-low; a request is pending while 0.
- `wr` in 1: 0 = store, 1 = load; valid when `cs`=0.
- `mask` in 4: byte-lane enables for stores; bit i covers `data_wr[8i+7:8i]`; ignored for loads.
- `addr` in 32: byte address; bits [1:0] are ignored (lanes are already positioned by the initiator).
- `data_wr` in 32: lane-aligned store data.
- `data_rd` out 32: full word read by the last completed load; 0 after an erroring load.
- `ready` out 1: one-cycle acknowledge of request completion.
- `err` out 1: high together with `ready` when the completed request was out of range.

## Operation
- The state machine has three states: IDLE, BUSY and DONE. A 4-bit wait counter `cnt` runs alongside it.
- **IDLE:** on an edge with `cs`=0, latch `addr`, `wr`, `mask` and `data_wr`, set `cnt`=`WAIT_STATES`, and go to BUSY. Otherwise stay in IDLE.
- **BUSY:** inputs are ignored.
  - If `cnt`≠0: decrement `cnt`.
  - If `cnt`=0: perform the access at this edge, set `ready`=1, and go to DONE.
- **DONE:** `ready` is high for exactly this cycle. Clear `ready`/`err` and go to IDLE unconditionally. A request present during DONE is not accepted; it is accepted in the following IDLE cycle.
- **Index and range:** compute `off = addr_latched - BASE_ADDR` as an unsigned 32-bit value and `idx = off[31:2]`. The request is in range iff `addr_latched >= BASE_ADDR` and `idx < DEPTH_WORDS`.
- **Store, in range:** for each i with `mask[i]`=1, `mem[idx][8i+7:8i] <= data_wr_latched[8i+7:8i]`. Other lanes are unchanged. `mask`=0 is a legal no-op with no error. `data_rd` is unchanged.
- **Load, in range:** `data_rd <= mem[idx]`, all four bytes regardless of `mask`. The load unit does sign/zero extension and lane selection.
- **Out of range:** no memory change. A load sets `data_rd <= 0`. `err`=1 with `ready`.
- `data_rd` holds its value until the next load completes.
- Memory contents are not reset and are undefined until written. The bench initialises them through stores.

## Timing
- Reset asserted, at any time: state=IDLE, `cnt`=0, `ready`=0, `err`=0, `data_rd`=32'h0. Memory is untouched.
- A request in flight when reset asserts is dropped: no write commits and no `ready` is produced.
- Latency: request accepted at edge E0. The access commits at edge E0+`WAIT_STATES`+1, which is also when `ready` rises. `ready` falls at the next edge.
- With `WAIT_STATES`=0, accept, commit and release take three edges per request. Sustained throughput is one request per `WAIT_STATES`+3 cycles if `cs` is held low continuously.
- Initiator rule: hold `cs`, `wr`, `addr`, `mask` and `data_wr` stable from accept until `ready` is sampled. Deassert or change them in the DONE cycle.
- Changes to inputs after accept have no effect on the current request.
- Store followed by a load to the same word: the load returns the updated data, because the store commits before the load is accepted.
- `ready` and `err` are registered outputs. `data_rd` is registered and valid in the same cycle `ready` is high.

## Test plan
- **Reset values:** assert `rst`=0 mid-run, then release → `ready`=0, `err`=0, `data_rd`=0 on every cycle until the first completion.
- **Word store/load, `WAIT_STATES`=2:** store 0xDEADBEEF to 0x10 with mask 1111 → `ready` 3 cycles after the accept edge, `err`=0. Then load 0x10 → `data_rd`=0xDEADBEEF with `ready`.
- **Byte and halfword stores:**
  - store 0x0000AB00 to 0x11 with mask 0010, then load → 0xDEADABEF.
  - store 0x12340000 to 0x12 with mask 1100, then load → 0x1234ABEF.
  - store with mask 0000 → word unchanged, `err`=0.
- **Out of range:**
  - store to `BASE_ADDR`+4*`DEPTH_WORDS` → `ready`=1, `err`=1, memory unchanged.
  - load from the same address → `data_rd`=0, `err`=1.
  - with `BASE_ADDR`=0x1000, load from 0x0FFC → `err`=1.
- **Reset mid-write:** store 0xCAFEF00D to 0x20 and assert `rst` during BUSY → no `ready`. After reset, a load of 0x20 returns its prior value.
- **Back-to-back, `WAIT_STATES`=0, `cs` held low:** store then load to 0x30 with no gap → `ready` pulses exactly every 3 cycles. The load returns the stored word. Input changes made during BUSY do not affect the committed data.

Source files
------------

// File: rtl/data_mem_responder.sv
// Word-organised data memory behind the load/store interface: latches one request,
// holds it for WAIT_STATES cycles, commits or reads it, then pulses ready (with err if out of range).
module data_mem_responder #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned WAIT_STATES = 1,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cs,
    input  logic        wr,
    input  logic [3:0]  mask,
    input  logic [31:0] addr,
    input  logic [31:0] data_wr,
    output logic [31:0] data_rd,
    output logic        ready,
    output logic        err
);

    localparam int unsigned IDX_W    = $clog2(DEPTH_WORDS);
    localparam logic [3:0]  WAIT_CNT = 4'(WAIT_STATES);
    localparam logic [29:0] BASE_W   = BASE_ADDR[31:2];

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state, state_next;
    logic [3:0]  cnt, cnt_next;
    logic        ready_next, err_next;
    logic [31:0] data_rd_next;
    logic        accept, commit;

    logic [29:0] addr_p0;
    logic        wr_p0;
    logic [3:0]  mask_p0;
    logic [31:0] data_wr_p0;

    logic [29:0]      word_off;
    logic             in_range;
    logic [IDX_W-1:0] idx;
    logic             unused_addr_lsb;

    logic [31:0] mem [DEPTH_WORDS];

    // The initiator positions lanes itself, so the byte offset within a word carries no information.
    assign unused_addr_lsb = ^addr[1:0];

    // Base is word aligned, so the range check can be done entirely on word addresses.
    assign word_off = addr_p0 - BASE_W;
    assign idx      = word_off[IDX_W-1:0];
    assign in_range = (addr_p0 >= BASE_W) && ({2'b00, word_off} < DEPTH_WORDS);

    always_comb begin
        state_next   = state;
        cnt_next     = cnt;
        ready_next   = 1'b0;
        err_next     = 1'b0;
        data_rd_next = data_rd;
        accept       = 1'b0;
        commit       = 1'b0;
        unique case (state)
            IDLE: begin
                if (!cs) begin
                    accept     = 1'b1;
                    cnt_next   = WAIT_CNT;
                    state_next = BUSY;
                end
            end
            BUSY: begin
                if (cnt != 4'd0) begin
                    cnt_next = cnt - 4'd1;
                end else begin
                    commit     = 1'b1;
                    ready_next = 1'b1;
                    err_next   = !in_range;
                    if (wr_p0) begin
                        data_rd_next = in_range ? mem[idx] : 32'h0;
                    end
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            cnt     <= 4'd0;
            ready   <= 1'b0;
            err     <= 1'b0;
            data_rd <= 32'h0;
        end else begin
            state   <= state_next;
            cnt     <= cnt_next;
            ready   <= ready_next;
            err     <= err_next;
            data_rd <= data_rd_next;
        end
    end

    // Request capture stage: fields are frozen at accept so later input changes are ignored.
    always_ff @(posedge clk) begin
        if (accept) begin
            addr_p0    <= addr[31:2];
            wr_p0      <= wr;
            mask_p0    <= mask;
            data_wr_p0 <= data_wr;
        end
    end

    // Commit stage: a reset forces IDLE first, so an in-flight store can never reach here.
    always_ff @(posedge clk) begin
        if (commit && !wr_p0 && in_range) begin
            for (int i = 0; i < 4; i++) begin
                if (mask_p0[i]) begin
                    mem[idx][8*i +: 8] <= data_wr_p0[8*i +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: three instances cover WAIT_STATES 2/0/1
// and a non-zero base address; each test task checks its own expected values.
module tb_data_mem_responder;

    logic        clk;
    logic        rst;
    logic        cs_v    [3];
    logic        wr_v    [3];
    logic [3:0]  mask_v  [3];
    logic [31:0] addr_v  [3];
    logic [31:0] wdata_v [3];
    logic [31:0] rdata_v [3];
    logic        ready_v [3];
    logic        err_v   [3];

    int errors = 0;
    int checks = 0;

    data_mem_responder #(.DEPTH_WORDS(1024), .WAIT_STATES(2), .BASE_ADDR(32'h0000_0000)) dut_a (
        .clk(clk), .rst(rst), .cs(cs_v[0]), .wr(wr_v[0]), .mask(mask_v[0]), .addr(addr_v[0]),
        .data_wr(wdata_v[0]), .data_rd(rdata_v[0]), .ready(ready_v[0]), .err(err_v[0]));

    data_mem_responder #(.DEPTH_WORDS(1024), .WAIT_STATES(0), .BASE_ADDR(32'h0000_0000)) dut_b (
        .clk(clk), .rst(rst), .cs(cs_v[1]), .wr(wr_v[1]), .mask(mask_v[1]), .addr(addr_v[1]),
        .data_wr(wdata_v[1]), .data_rd(rdata_v[1]), .ready(ready_v[1]), .err(err_v[1]));

    data_mem_responder #(.DEPTH_WORDS(16), .WAIT_STATES(1), .BASE_ADDR(32'h0000_1000)) dut_c (
        .clk(clk), .rst(rst), .cs(cs_v[2]), .wr(wr_v[2]), .mask(mask_v[2]), .addr(addr_v[2]),
        .data_wr(wdata_v[2]), .data_rd(rdata_v[2]), .ready(ready_v[2]), .err(err_v[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Issue one request on instance k; lat = edges after the accept edge until ready (-1 on timeout).
    task automatic do_req(input int k, input logic w, input logic [3:0] m, input logic [31:0] a,
                          input logic [31:0] d, output int lat, output logic [31:0] rd,
                          output logic e, output logic rdy_after);
        cs_v[k]    = 1'b0;
        wr_v[k]    = w;
        mask_v[k]  = m;
        addr_v[k]  = a;
        wdata_v[k] = d;
        lat = -1;
        rd  = 32'hxxxx_xxxx;
        e   = 1'bx;
        for (int n = 0; n < 30; n++) begin
            @(posedge clk); #1;
            if (ready_v[k] === 1'b1) begin
                lat = n;
                rd  = rdata_v[k];
                e   = err_v[k];
                break;
            end
        end
        cs_v[k] = 1'b1;
        @(posedge clk); #1;
        rdy_after = ready_v[k];
    endtask

    task automatic test_reset();
        rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            for (int k = 0; k < 3; k++) begin
                checks++;
                if (ready_v[k] !== 1'b0 || err_v[k] !== 1'b0 || rdata_v[k] !== 32'h0) begin
                    errors++;
                    $display("FAIL reset_hold[%0d]: got ready=%b err=%b data_rd=%h expected 0/0/00000000",
                             k, ready_v[k], err_v[k], rdata_v[k]);
                end
            end
        end
        rst = 1'b1;
        for (int c = 0; c < 2; c++) begin
            @(posedge clk); #1;
            checks++;
            if (ready_v[0] !== 1'b0 || err_v[0] !== 1'b0 || rdata_v[0] !== 32'h0) begin
                errors++;
                $display("FAIL reset_release: got ready=%b err=%b data_rd=%h expected 0/0/00000000",
                         ready_v[0], err_v[0], rdata_v[0]);
            end
        end
    endtask

    task automatic test_word();
        int lat; logic [31:0] rd; logic e, ra;
        do_req(0, 1'b0, 4'hF, 32'h0000_0000, 32'hA5A5_A5A5, lat, rd, e, ra);
        do_req(0, 1'b0, 4'hF, 32'h0000_0020, 32'h1122_3344, lat, rd, e, ra);
        do_req(0, 1'b0, 4'hF, 32'h0000_0010, 32'hDEAD_BEEF, lat, rd, e, ra);
        checks++;
        if (lat !== 3) begin errors++; $display("FAIL word_store_latency: got %0d expected 3", lat); end
        checks++;
        if (e !== 1'b0) begin errors++; $display("FAIL word_store_err: got %b expected 0", e); end
        checks++;
        if (ra !== 1'b0) begin errors++; $display("FAIL ready_one_cycle: got %b expected 0", ra); end
        do_req(0, 1'b1, 4'h0, 32'h0000_0010, 32'h0, lat, rd, e, ra);
        checks++;
        if (rd !== 32'hDEAD_BEEF || lat !== 3) begin
            errors++; $display("FAIL word_load: got %h lat %0d expected deadbeef lat 3", rd, lat);
        end
    endtask

    task automatic test_reset_midrun();
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        checks++;
        if (rdata_v[0] !== 32'h0) begin
            errors++; $display("FAIL reset_async_data_rd: got %h expected 00000000", rdata_v[0]);
        end
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            checks++;
            if (ready_v[0] !== 1'b0 || err_v[0] !== 1'b0 || rdata_v[0] !== 32'h0) begin
                errors++;
                $display("FAIL reset_midrun: got ready=%b err=%b data_rd=%h expected 0/0/00000000",
                         ready_v[0], err_v[0], rdata_v[0]);
            end
        end
    endtask

    task automatic test_byte_lanes();
        int lat; logic [31:0] rd; logic e, ra;
        do_req(0, 1'b0, 4'b0010, 32'h0000_0011, 32'h0000_AB00, lat, rd, e, ra);
        do_req(0, 1'b1, 4'h0, 32'h0000_0011, 32'h0, lat, rd, e, ra);
        checks++;
        if (rd !== 32'hDEAD_ABEF) begin errors++; $display("FAIL byte_store: got %h expected deadabef", rd); end
        do_req(0, 1'b0, 4'b1100, 32'h0000_0012, 32'h1234_0000, lat, rd, e, ra);
        do_req(0, 1'b1, 4'h0, 32'h0000_0010, 32'h0, lat, rd, e, ra);
        checks++;
        if (rd !== 32'h1234_ABEF) begin errors++; $display("FAIL half_store: got %h expected 1234abef", rd); end
        do_req(0, 1'b0, 4'b0000, 32'h0000_0010, 32'hFFFF_FFFF, lat, rd, e, ra);
        checks++;
        if (e !== 1'b0 || lat !== 3) begin
            errors++; $display("FAIL mask0_err: got err=%b lat %0d expected err=0 lat 3", e, lat);
        end
        do_req(0, 1'b1, 4'h0, 32'h0000_0010, 32'h0, lat, rd, e, ra);
        checks++;
        if (rd !== 32'h1234_ABEF) begin errors++; $display("FAIL mask0_unchanged: got %h expected 1234abef", rd); end
    endtask

    task automatic test_out_of_range();
        int lat; logic [31:0] rd; logic e, ra;
        do_req(0, 1'b0, 4'hF, 32'h0000_1000, 32'h5555_5555, lat, rd, e, ra);
        checks++;
        if (e !== 1'b1 || lat !== 3) begin
            errors++; $display("FAIL oor_store: got err=%b lat %0d expected err=1 lat 3", e, lat);
        end
        do_req(0, 1'b1, 4'h0, 32'h0000_1000, 32'h0, lat, rd, e, ra);
        checks++;
        if (e !== 1'b1 || rd !== 32'h0) begin
            errors++; $display("FAIL oor_load: got err=%b data_rd=%h expected err=1 data_rd=00000000", e, rd);
        end
        do_req(0, 1'b1, 4'h0, 32'h0000_0000, 32'h0, lat, rd, e, ra);
        checks++;
        if (e !== 1'b0 || rd !== 32'hA5A5_A5A5) begin
            errors++; $display("FAIL oor_no_alias: got err=%b data_rd=%h expected err=0 data_rd=a5a5a5a5", e, rd);
        end
    endtask

    task automatic test_base_addr();
        int lat; logic [31:0] rd; logic e, ra;
        do_req(2, 1'b1, 4'h0, 32'h0000_0FFC, 32'h0, lat, rd, e, ra);
        checks++;
        if (e !== 1'b1 || rd !== 32'h0 || lat !== 2) begin
            errors++; $display("FAIL below_base: got err=%b data_rd=%h lat %0d expected 1/00000000/2", e, rd, lat);
        end
        do_req(2, 1'b0, 4'hF, 32'h0000_1000, 32'h1357_9BDF, lat, rd, e, ra);
        do_req(2, 1'b0, 4'hF, 32'h0000_103C, 32'h600D_CAFE, lat, rd, e, ra);
        checks++;
        if (e !== 1'b0) begin errors++; $display("FAIL last_word_store_err: got %b expected 0", e); end
        do_req(2, 1'b1, 4'h0, 32'h0000_103C, 32'h0, lat, rd, e, ra);
        checks++;
        if (rd !== 32'h600D_CAFE || e !== 1'b0) begin
            errors++; $display("FAIL last_word_load: got %h err=%b expected 600dcafe err=0", rd, e);
        end
        do_req(2, 1'b0, 4'hF, 32'h0000_1040, 32'hFFFF_0000, lat, rd, e, ra);
        checks++;
        if (e !== 1'b1) begin errors++; $display("FAIL above_top_err: got %b expected 1", e); end
        do_req(2, 1'b1, 4'h0, 32'h0000_1000, 32'h0, lat, rd, e, ra);
        checks++;
        if (rd !== 32'h1357_9BDF) begin errors++; $display("FAIL above_top_unchanged: got %h expected 13579bdf", rd); end
    endtask

    task automatic test_reset_mid_write();
        int lat; logic [31:0] rd; logic e, ra;
        cs_v[0] = 1'b0; wr_v[0] = 1'b0; mask_v[0] = 4'hF;
        addr_v[0] = 32'h0000_0020; wdata_v[0] = 32'hCAFE_F00D;
        @(posedge clk); #1;
        rst = 1'b0;
        cs_v[0] = 1'b1;
        for (int c = 0; c < 6; c++) begin
            if (c == 2) rst = 1'b1;
            @(posedge clk); #1;
            checks++;
            if (ready_v[0] !== 1'b0) begin
                errors++; $display("FAIL reset_drop_ready cycle %0d: got %b expected 0", c, ready_v[0]);
            end
        end
        do_req(0, 1'b1, 4'h0, 32'h0000_0020, 32'h0, lat, rd, e, ra);
        checks++;
        if (rd !== 32'h1122_3344) begin errors++; $display("FAIL reset_drop_mem: got %h expected 11223344", rd); end
    endtask

    task automatic test_back_to_back();
        int lat; logic [31:0] rd; logic e, ra;
        logic [8:0]  r;
        logic [31:0] rd4, rd7;
        do_req(1, 1'b0, 4'hF, 32'h0000_0034, 32'h7777_7777, lat, rd, e, ra);
        checks++;
        if (lat !== 1) begin errors++; $display("FAIL ws0_latency: got %0d expected 1", lat); end
        do_req(1, 1'b0, 4'hF, 32'h0000_0030, 32'h0000_0000, lat, rd, e, ra);
        r = '0; rd4 = '0; rd7 = '0;
        cs_v[1] = 1'b0; wr_v[1] = 1'b0; mask_v[1] = 4'hF;
        addr_v[1] = 32'h0000_0030; wdata_v[1] = 32'h0BAD_F00D;
        for (int n = 0; n < 9; n++) begin
            @(posedge clk); #1;
            r[n] = ready_v[1];
            case (n)
                0: begin wdata_v[1] = 32'hFFFF_FFFF; addr_v[1] = 32'h0000_0034; mask_v[1] = 4'h0; end
                1: begin wr_v[1] = 1'b1; addr_v[1] = 32'h0000_0030; wdata_v[1] = 32'h0; end
                3: addr_v[1] = 32'h0000_0034;
                4: begin rd4 = rdata_v[1]; addr_v[1] = 32'h0000_0030; end
                7: rd7 = rdata_v[1];
                default: ;
            endcase
        end
        cs_v[1] = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (r !== 9'b010010010) begin errors++; $display("FAIL b2b_ready_pattern: got %b expected 010010010", r); end
        checks++;
        if (rd4 !== 32'h0BAD_F00D) begin errors++; $display("FAIL b2b_first_load: got %h expected 0badf00d", rd4); end
        checks++;
        if (rd7 !== 32'h0BAD_F00D) begin errors++; $display("FAIL b2b_second_load: got %h expected 0badf00d", rd7); end
        do_req(1, 1'b1, 4'h0, 32'h0000_0034, 32'h0, lat, rd, e, ra);
        checks++;
        if (rd !== 32'h7777_7777) begin errors++; $display("FAIL b2b_neighbour: got %h expected 77777777", rd); end
    endtask

    initial begin
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            cs_v[k] = 1'b1; wr_v[k] = 1'b1; mask_v[k] = 4'h0; addr_v[k] = 32'h0; wdata_v[k] = 32'h0;
        end
        test_reset();
        test_word();
        test_reset_midrun();
        test_byte_lanes();
        test_out_of_range();
        test_base_addr();
        test_reset_mid_write();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
